if_queue: RTL and testbench
===========================

# if_queue

Instruction fetch queue between the fetch stage (PC generation, branch prediction) and decode. Each cycle it accepts one fetched {PC, instruction, prediction, trap} packet and buffers up to DEPTH packets. It presents them in order to decode over a valid/ready handshake. It drains instantly on an execute-stage mispredict flush, and its `in_ready` drives the fetch stage's `ready` input.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥ 2.
- `PC_W`, 48: PC width.
- `clk` input 1: clock, rising edge.
- `n_reset` input 1: asynchronous, active-low reset.
- `flush` input 1: mispredict from execute (`mispred_ex`); empties the queue.
- `in_valid` input 1: fetch packet valid.
- `in_ready` output 1: queue can accept a packet this cycle.
- `in_pc` input PC_W: PC of fetched instruction.
- `in_instr` input 32: fetched instruction word.
- `in_pred_taken` input 1: predictor redirected after this instruction.
- `in_trap` input 1: fetch misalignment trap for this PC.
- `out_valid` output 1: head packet valid.
- `out_ready` input 1: decode accepts head packet.
- `out_pc` output PC_W, `out_instr` output 32, `out_pred_taken` output 1, `out_trap` output 1: head packet fields.
- `count` output $clog2(DEPTH)+1: current occupancy.

## Operation
- Storage is a circular buffer with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a separate occupancy counter `count` in 0..DEPTH.
- Push occurs when `in_valid && in_ready && !flush`. The entry is written at tail and tail increments.
- Pop occurs when `out_valid && out_ready && !flush`. Head increments.
- Simultaneous push and pop leaves `count` unchanged. This is legal at any occupancy 1..DEPTH-1.
- `in_ready = (count < DEPTH) && !trap_pending`. It is not raised by a same-cycle pop when full, so there is no combinational path from `out_ready` to `in_ready`.
- `out_valid = (count != 0)`. The head fields are read combinationally from storage at head.
- Trap entries:
  - A pushed packet with `in_trap=1` stores instr as 32'h00000013 (NOP), regardless of `in_instr`.
  - It sets `trap_pending`, which blocks further pushes. The trap must be the youngest entry.
  - `trap_pending` clears only on `flush` or reset.
- Flush: head, tail and count go to 0 and `trap_pending` goes to 0 on the next edge. Any push or pop presented in the flush cycle is discarded. Stored data is not cleared.
- Reset (async, any time, including mid-push or full):
  - head, tail and count are 0, and `trap_pending` is 0.
  - `out_valid`=0 and `in_ready`=1.
  - `out_pc`, `out_instr`, `out_pred_taken` and `out_trap` read 0, because storage resets to 0.

## Timing
- Latency without bypass: a packet pushed at edge N appears on `out_*` after edge N, so decode can consume it in cycle N+1.
- Throughput: one packet per cycle sustained when decode is always ready.
- Full: with `count`==DEPTH, `in_ready`=0 for that whole cycle. A pop at that edge makes `in_ready`=1 the following cycle.
- Empty: a pop is impossible because `out_valid`=0. `out_ready` is ignored.
- Flush cycle: `out_valid` and `in_ready` still reflect the pre-flush state during that cycle. After the edge, `out_valid`=0 and `in_ready`=1.
- Upstream contract: the fetch stage holds `in_*` stable while `in_valid && !in_ready`.

## Configuration
- `IFQ_BYPASS_EN` defined: when `count`==0 and not flushing, an incoming packet is forwarded combinationally.
  - `out_valid` = `in_valid` and `out_*` = `in_*`, with the trap NOP substitution applied.
  - If `out_ready`=1, the packet is consumed without being written and `count` stays 0.
  - If `out_ready`=0, it is written normally.
  - `in_ready` logic is unchanged.
  - Latency is 0 cycles when empty.
- `IFQ_BYPASS_EN` undefined: there is no bypass, and every packet incurs 1 cycle of latency as described under Timing.

## Test plan
- Reset, then push PC 0x0, 0x4, 0x8, 0xC back-to-back with `out_ready`=0:
  - `count` reaches 4 and `in_ready`=0 on the 5th cycle.
  - Then raise `out_ready` and pops return 0x0, 0x4, 0x8, 0xC in order with instrs intact.
- Streaming test:
  - Drive `in_valid`=1 and `out_ready`=1 for 20 cycles with PC incrementing by 4.
  - `count` stays 1 without bypass and 0 with bypass.
  - Output PCs form a continuous sequence with no gaps; pointers wrap past DEPTH with no loss or duplication.
- Trap test:
  - Push 0x100, then 0x102 with `in_trap`=1 and `in_instr`=0xDEADBEEF.
  - Second pop shows `out_trap`=1 and `out_instr`=0x00000013.
  - `in_ready` stays 0 until `flush`, then returns to 1.
- Flush test:
  - Assert `flush` with `count`=3 while also presenting a push and a pop.
  - Next cycle `count`=0, `out_valid`=0 and `in_ready`=1.
  - The discarded push does not appear later.
- Asynchronous reset test:
  - Drop `n_reset` mid-cycle while the queue is full.
  - `out_valid`=0, `count`=0 and `in_ready`=1 immediately, before the next clock edge.
  - After release, the first push of 0x200 is the first pop.
- Bypass test (only with `IFQ_BYPASS_EN` defined):
  - With the queue empty, push 0x300 with `out_ready`=1.
  - `out_pc`=0x300 in the same cycle and `count` remains 0.

Source files
------------

// File: rtl/if_queue.sv
// if_queue: in-order fetch-to-decode packet queue with mispredict flush and trap blocking.
// Optional IFQ_BYPASS_EN forwards a packet straight to decode when the queue is empty.
module if_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 48
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     in_pred_taken,
  input  logic                     in_trap,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [31:0]              out_instr,
  output logic                     out_pred_taken,
  output logic                     out_trap,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW-1:0] STEP = AW'(1);
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [PC_W-1:0] pc_mem [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic [DEPTH-1:0] pred_mem, trap_mem;
  logic [AW-1:0] head, tail;
  logic trap_pending, accept, byp, push, pop;
  logic [31:0] in_word;
  assign in_ready = (count < FULL) && !trap_pending;
  assign accept = in_valid && in_ready && !flush;
  assign in_word = in_trap ? NOP : in_instr;
`ifdef IFQ_BYPASS_EN
  assign byp = (count == '0) && accept;
`else
  assign byp = 1'b0;
`endif
  assign out_valid = (count != '0) || byp;
  assign out_pc = byp ? in_pc : pc_mem[head];
  assign out_instr = byp ? in_word : instr_mem[head];
  assign out_pred_taken = byp ? in_pred_taken : pred_mem[head];
  assign out_trap = byp ? in_trap : trap_mem[head];
  // a forwarded packet taken by decode never touches storage
  assign push = accept && !(byp && out_ready);
  assign pop = (count != '0) && out_ready && !flush;
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      trap_pending <= 1'b0;
      pred_mem <= '0;
      trap_mem <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i] <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      trap_pending <= 1'b0;
    end else begin
      if (push) begin
        pc_mem[tail] <= in_pc;
        instr_mem[tail] <= in_word;
        pred_mem[tail] <= in_pred_taken;
        trap_mem[tail] <= in_trap;
        tail <= tail + STEP;
      end
      if (pop) head <= head + STEP;
      count <= (push && !pop) ? count + ONE : (!push && pop) ? count - ONE : count;
      if (accept && in_trap) trap_pending <= 1'b1;
    end
  end
endmodule

// File: tb/tb_if_queue.sv
// tb_if_queue: directed checks of if_queue ordering, streaming, traps, flush and async reset.
module tb_if_queue;
  logic clk = 1'b0, n_reset = 1'b0, flush = 1'b0;
  logic in_valid = 1'b0, in_ready, in_pred_taken = 1'b0, in_trap = 1'b0;
  logic [47:0] in_pc = '0, out_pc;
  logic [31:0] in_instr = '0, out_instr;
  logic out_valid, out_ready = 1'b0, out_pred_taken, out_trap;
  logic [2:0] count;
  int vecs = 0, errs = 0;

  if_queue #(.DEPTH(4), .PC_W(48)) dut (
    .clk(clk), .n_reset(n_reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_pred_taken(in_pred_taken), .in_trap(in_trap),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_pred_taken(out_pred_taken), .out_trap(out_trap), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL reset_count got %0d exp 0", count); end
    vecs++; if (out_pc !== 48'h0 || out_instr !== 32'h0) begin errs++; $display("FAIL reset_out_fields got pc %h instr %h exp 0", out_pc, out_instr); end
    @(negedge clk);
    n_reset = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 48'(4 * i); in_instr = 32'h1000 + i; in_pred_taken = i[0];
      tick();
    end
    in_valid = 1'b0;
    #1;
    vecs++; if (count !== 3'd4) begin errs++; $display("FAIL fill_count got %0d exp 4", count); end
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL fill_in_ready got %b exp 0", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vecs++; if (out_valid !== 1'b1 || out_pc !== 48'(4 * i)) begin errs++; $display("FAIL drain_pc[%0d] got v%b %h exp %h", i, out_valid, out_pc, 4 * i); end
      vecs++; if (out_instr !== 32'h1000 + i || out_pred_taken !== i[0]) begin errs++; $display("FAIL drain_instr[%0d] got %h/%b exp %h/%b", i, out_instr, out_pred_taken, 32'h1000 + i, i[0]); end
      tick();
    end
    #1;
    vecs++; if (count !== 3'd0 || out_valid !== 1'b0) begin errs++; $display("FAIL drain_empty got count %0d v%b exp 0 0", count, out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_stream();
    logic [47:0] exp_pc = 48'h1000;
    int exp_cnt;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; in_pc = 48'h1000 + 48'(4 * k); in_instr = 32'(k);
      #1;
`ifdef IFQ_BYPASS_EN
      exp_cnt = 0;
`else
      exp_cnt = (k == 0) ? 0 : 1;
`endif
      vecs++; if (count !== 3'(exp_cnt)) begin errs++; $display("FAIL stream_count[%0d] got %0d exp %0d", k, count, exp_cnt); end
      if (out_valid) begin
        vecs++; if (out_pc !== exp_pc) begin errs++; $display("FAIL stream_pc[%0d] got %h exp %h", k, out_pc, exp_pc); end
        exp_pc = exp_pc + 48'd4;
      end
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (out_valid) begin
        vecs++; if (out_pc !== exp_pc) begin errs++; $display("FAIL stream_tail_pc got %h exp %h", out_pc, exp_pc); end
        exp_pc = exp_pc + 48'd4;
      end
      tick();
    end
    vecs++; if (exp_pc !== 48'h1000 + 48'd80) begin errs++; $display("FAIL stream_total got next %h exp %h", exp_pc, 48'h1050); end
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL stream_final_count got %0d exp 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_trap();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 48'h100; in_instr = 32'h1111_1111; in_trap = 1'b0;
    tick();
    in_pc = 48'h102; in_instr = 32'hDEAD_BEEF; in_trap = 1'b1;
    tick();
    in_valid = 1'b0; in_trap = 1'b0;
    #1;
    vecs++; if (in_ready !== 1'b0 || count !== 3'd2) begin errs++; $display("FAIL trap_block got rdy %b count %0d exp 0 2", in_ready, count); end
    out_ready = 1'b1;
    #1;
    vecs++; if (out_pc !== 48'h100 || out_trap !== 1'b0) begin errs++; $display("FAIL trap_first got %h/%b exp 100/0", out_pc, out_trap); end
    tick();
    vecs++; if (out_pc !== 48'h102 || out_trap !== 1'b1 || out_instr !== 32'h13) begin errs++; $display("FAIL trap_second got %h/%b/%h exp 102/1/00000013", out_pc, out_trap, out_instr); end
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 48'h104; in_instr = 32'h2222_2222;
    tick();
    in_valid = 1'b0;
    vecs++; if (in_ready !== 1'b0 || count !== 3'd0) begin errs++; $display("FAIL trap_hold got rdy %b count %0d exp 0 0", in_ready, count); end
    flush = 1'b1;
    #1;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL trap_flush_cycle got rdy %b exp 0", in_ready); end
    tick();
    flush = 1'b0;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL trap_cleared got rdy %b exp 1", in_ready); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 48'h400 + 48'(4 * i); in_instr = 32'h4000 + i;
      tick();
    end
    in_pc = 48'h40C; in_instr = 32'h400C; out_ready = 1'b1; flush = 1'b1;
    #1;
    vecs++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || count !== 3'd3) begin errs++; $display("FAIL flush_pre got v%b rdy %b count %0d exp 1 1 3", out_valid, in_ready, count); end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    vecs++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL flush_post got count %0d v%b rdy %b exp 0 0 1", count, out_valid, in_ready); end
    in_valid = 1'b1; in_pc = 48'h500; in_instr = 32'h5000;
    tick();
    in_valid = 1'b0;
    vecs++; if (out_pc !== 48'h500 || count !== 3'd1) begin errs++; $display("FAIL flush_no_ghost got %h count %0d exp 500 1", out_pc, count); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 48'h600 + 48'(4 * i); in_instr = 32'h6000 + i;
      tick();
    end
    #2;
    n_reset = 1'b0;
    #1;
    vecs++; if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin errs++; $display("FAIL async_reset got v%b count %0d rdy %b exp 0 0 1", out_valid, count, in_ready); end
    in_valid = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    tick();
    in_valid = 1'b1; in_pc = 48'h200; in_instr = 32'h2000;
    tick();
    in_valid = 1'b0;
    vecs++; if (out_valid !== 1'b1 || out_pc !== 48'h200 || count !== 3'd1) begin errs++; $display("FAIL async_first_pop got v%b %h count %0d exp 1 200 1", out_valid, out_pc, count); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

`ifdef IFQ_BYPASS_EN
  task automatic test_bypass();
    in_valid = 1'b1; in_pc = 48'h300; in_instr = 32'h3000; out_ready = 1'b1;
    #1;
    vecs++; if (out_valid !== 1'b1 || out_pc !== 48'h300 || out_instr !== 32'h3000) begin errs++; $display("FAIL bypass_fwd got v%b %h %h exp 1 300 3000", out_valid, out_pc, out_instr); end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    vecs++; if (count !== 3'd0 || out_valid !== 1'b0) begin errs++; $display("FAIL bypass_count got %0d v%b exp 0 0", count, out_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_drain();
    test_stream();
    test_trap();
    test_flush();
    test_async_reset();
`ifdef IFQ_BYPASS_EN
    test_bypass();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
